// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for the combinational ALU: decodes one integer
// op, drives the ALU for one cycle, then resolves result or branch outcome.
module alu_issue_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_imm,
    input  logic [TAG_W-1:0] req_tag,
    output logic [2:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    input  logic [2:0]       alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_taken,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;

    localparam logic [1:0] M_ARITH = 2'd0;
    localparam logic [1:0] M_SLT   = 2'd1;
    localparam logic [1:0] M_BR    = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_alu_op;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [1:0]       r_mode;
    logic [2:0]       r_funct3;
    logic [TAG_W-1:0] r_tag;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_result;
    logic             r_rsp_taken;
    logic             r_rsp_err;
    logic [TAG_W-1:0] r_rsp_tag;

    logic             w_accept;
    logic [2:0]       w_op;
    logic             w_err;
    logic [1:0]       w_mode;
    logic [31:0]      w_b;
    logic             w_n;
    logic             w_v;
    logic             w_z;
    logic             w_lt;
    logic             w_taken;
    logic [31:0]      w_result;

    assign req_ready = (r_state == S_IDLE) & !reset;
    assign w_accept  = req_valid & req_ready;
    assign w_b       = (req_kind == 2'b01) ? req_imm : req_rs2;

    always_comb begin
        w_op   = OP_ADD;
        w_err  = 1'b0;
        w_mode = M_ARITH;
        case (req_kind)
            2'b00, 2'b01: begin
                case (req_funct3)
                    3'b000: begin
                        if (req_kind == 2'b00 && req_funct7b5)
                            w_op = OP_SUB;
                        else
                            w_op = OP_ADD;
                    end
                    3'b111: w_op = OP_AND;
                    3'b110: w_op = OP_OR;
                    3'b010: begin
                        w_op   = OP_SUB;
                        w_mode = M_SLT;
                    end
                    default: w_err = 1'b1;
                endcase
            end
            2'b10: begin
                w_op   = OP_SUB;
                w_mode = M_BR;
                case (req_funct3)
                    3'b000, 3'b001, 3'b100, 3'b101: w_err = 1'b0;
                    default: w_err = 1'b1;
                endcase
            end
            default: w_err = 1'b1;
        endcase
    end

    // Signed less-than comes from the subtract's sign corrected by overflow
    assign w_n  = alu_status[2];
    assign w_v  = alu_status[1];
    assign w_z  = alu_status[0];
    assign w_lt = w_n ^ w_v;

    always_comb begin
        w_taken = 1'b0;
        if (r_mode == M_BR) begin
            case (r_funct3)
                3'b000:  w_taken = w_z;
                3'b001:  w_taken = !w_z;
                3'b100:  w_taken = w_lt;
                3'b101:  w_taken = !w_lt;
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_result = alu_out;
        if (r_mode == M_SLT)
            w_result = {31'b0, w_lt};
        else if (r_mode == M_BR)
            w_result = 32'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_alu_op     <= OP_AND;
            r_alu_a      <= 32'b0;
            r_alu_b      <= 32'b0;
            r_mode       <= M_ARITH;
            r_funct3     <= 3'b0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'b0;
            r_rsp_taken  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_tag    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= 32'b0;
                            r_rsp_taken  <= 1'b0;
                            r_rsp_err    <= 1'b1;
                            r_rsp_tag    <= req_tag;
                            r_state      <= S_RESP;
                        end else begin
                            r_alu_op <= w_op;
                            r_alu_a  <= req_rs1;
                            r_alu_b  <= w_b;
                            r_mode   <= w_mode;
                            r_funct3 <= req_funct3;
                            r_tag    <= req_tag;
                            r_state  <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= w_result;
                    r_rsp_taken  <= w_taken;
                    r_rsp_err    <= 1'b0;
                    r_rsp_tag    <= r_tag;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_taken  = r_rsp_taken;
    assign rsp_err    = r_rsp_err;
    assign rsp_tag    = r_rsp_tag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed vector bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic [2:0]       req_funct3;
    logic             req_funct7b5;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [31:0]      req_imm;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_out;
    logic [2:0]       alu_status;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_taken;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_funct3(req_funct3),
        .req_funct7b5(req_funct7b5),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_tag(req_tag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_taken(rsp_taken),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag)
    );

    logic [31:0] m_diff;
    always_comb begin
        m_diff = alu_a - alu_b;
        case (alu_op)
            3'b010:  alu_out = alu_a + alu_b;
            3'b110:  alu_out = m_diff;
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a | alu_b;
            default: alu_out = 32'b0;
        endcase
        alu_status[2] = alu_out[31];
        alu_status[1] = (alu_a[31] != alu_b[31]) && (m_diff[31] != alu_a[31]);
        alu_status[0] = (alu_out == 32'b0);
    end

    typedef struct {
        string       name;
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  tag;
        logic [2:0]  op;
        logic [31:0] res;
        logic        taken;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [2:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] expb;
        int          lat;
        int          explat;
        expb   = (v.kind == 2'b01) ? v.imm : v.rs2;
        explat = v.err ? 1 : 2;
        @(negedge clk);
        op0 = alu_op;
        a0  = alu_a;
        b0  = alu_b;
        req_kind     = v.kind;
        req_funct3   = v.f3;
        req_funct7b5 = v.f7;
        req_rs1      = v.rs1;
        req_rs2      = v.rs2;
        req_imm      = v.imm;
        req_tag      = v.tag;
        req_valid    = 1'b1;
        #1;
        chk({v.name, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (v.err) begin
            chk({v.name, ".op_hold"}, 32'(alu_op), 32'(op0));
            chk({v.name, ".a_hold"}, alu_a, a0);
            chk({v.name, ".b_hold"}, alu_b, b0);
        end else begin
            chk({v.name, ".alu_op"}, 32'(alu_op), 32'(v.op));
            chk({v.name, ".alu_a"}, alu_a, v.rs1);
            chk({v.name, ".alu_b"}, alu_b, expb);
        end
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, ".latency"}, 32'(lat), 32'(explat));
        chk({v.name, ".result"}, rsp_result, v.res);
        chk({v.name, ".taken"}, 32'(rsp_taken), 32'(v.taken));
        chk({v.name, ".err"}, 32'(rsp_err), 32'(v.err));
        chk({v.name, ".tag"}, 32'(rsp_tag), 32'(v.tag));
        @(posedge clk);
        #1;
        chk({v.name, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({v.name, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{"add",  2'b00, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h1,
                     32'h0, 5'd3, 3'b010, 32'h80000000, 1'b0, 1'b0};
        vecs[1]  = '{"sub",  2'b00, 3'b000, 1'b1, 32'd5, 32'd7,
                     32'h0, 5'd4, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{"slt1", 2'b00, 3'b010, 1'b0, 32'h80000000, 32'h1,
                     32'h0, 5'd5, 3'b110, 32'h1, 1'b0, 1'b0};
        vecs[3]  = '{"slt0", 2'b00, 3'b010, 1'b0, 32'h1, 32'h80000000,
                     32'h0, 5'd6, 3'b110, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{"addi", 2'b01, 3'b000, 1'b1, 32'd10, 32'h55,
                     32'hFFFFFFFF, 5'd7, 3'b010, 32'd9, 1'b0, 1'b0};
        vecs[5]  = '{"and",  2'b00, 3'b111, 1'b0, 32'hF0F0FFFF, 32'h0FF01234,
                     32'h0, 5'd8, 3'b000, 32'h00F01234, 1'b0, 1'b0};
        vecs[6]  = '{"ori",  2'b01, 3'b110, 1'b0, 32'h12340000, 32'hFFFFFFFF,
                     32'h0000ABCD, 5'd9, 3'b001, 32'h1234ABCD, 1'b0, 1'b0};
        vecs[7]  = '{"beq",  2'b10, 3'b000, 1'b0, 32'h1234, 32'h1234,
                     32'h0, 5'd10, 3'b110, 32'h0, 1'b1, 1'b0};
        vecs[8]  = '{"bne",  2'b10, 3'b001, 1'b0, 32'h1234, 32'h1234,
                     32'h0, 5'd11, 3'b110, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{"blt",  2'b10, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h0,
                     32'h0, 5'd12, 3'b110, 32'h0, 1'b1, 1'b0};
        vecs[10] = '{"bge",  2'b10, 3'b101, 1'b0, 32'h7FFFFFFF, 32'h80000000,
                     32'h0, 5'd13, 3'b110, 32'h0, 1'b1, 1'b0};
        vecs[11] = '{"bltu", 2'b10, 3'b110, 1'b0, 32'h1, 32'h2,
                     32'h0, 5'd14, 3'b000, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{"kind3", 2'b11, 3'b000, 1'b0, 32'h3, 32'h4,
                     32'h0, 5'd15, 3'b000, 32'h0, 1'b0, 1'b1};
        vecs[13] = '{"sll",  2'b00, 3'b001, 1'b0, 32'h3, 32'h1,
                     32'h0, 5'd16, 3'b000, 32'h0, 1'b0, 1'b1};
        vecs[14] = '{"bltn", 2'b10, 3'b100, 1'b0, 32'd5, 32'd3,
                     32'h0, 5'd17, 3'b110, 32'h0, 1'b0, 1'b0};

        reset = 1'b1;
        req_valid = 1'b0;
        req_kind = 2'b00;
        req_funct3 = 3'b000;
        req_funct7b5 = 1'b0;
        req_rs1 = 32'h0;
        req_rs2 = 32'h0;
        req_imm = 32'h0;
        req_tag = '0;
        rsp_ready = 1'b1;

        @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'd0);
        chk("rst.alu_a", alu_a, 32'd0);
        chk("rst.rsp_tag", 32'(rsp_tag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i]);

        // Backpressure: response must hold while consumer stalls
        @(negedge clk);
        rsp_ready = 1'b0;
        req_kind = 2'b00;
        req_funct3 = 3'b000;
        req_funct7b5 = 1'b0;
        req_rs1 = 32'd2;
        req_rs2 = 32'd3;
        req_tag = 5'd21;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp.valid", 32'(rsp_valid), 32'd1);
        req_tag = 5'd22;
        req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp.hold_result", rsp_result, 32'd5);
            chk("bp.hold_tag", 32'(rsp_tag), 32'd21);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.drop", 32'(rsp_valid), 32'd0);
        chk("bp.ready_back", 32'(req_ready), 32'd1);
        run_vec(vecs[1]);

        // Reset while in EXEC aborts the op
        @(negedge clk);
        req_kind = 2'b00;
        req_funct3 = 3'b000;
        req_funct7b5 = 1'b0;
        req_rs1 = 32'd100;
        req_rs2 = 32'd1;
        req_tag = 5'd25;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rx.in_exec_op", 32'(alu_op), 32'b010);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rx.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rx.alu_op", 32'(alu_op), 32'd0);
        chk("rx.alu_a", alu_a, 32'd0);
        chk("rx.alu_b", alu_b, 32'd0);
        chk("rx.rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rx.rsp_result", rsp_result, 32'd0);
        chk("rx.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rx.no_rsp", 32'(rsp_valid), 32'd0);
        run_vec(vecs[0]);
        run_vec(vecs[12]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front end for the combinational `alu`. It accepts one decoded integer instruction per request over a valid/ready handshake and encodes it into the ALU's `ALUop` code and operands. It then captures `out` and the `{N,V,Z}` status one cycle later and resolves the result or branch decision. Each outcome is returned over a second valid/ready handshake. It sits between the decode stage and writeback/PC-select, and is the only driver of the ALU's inputs.

## Interface
- `TAG_W`, default 5: width of the request/response tag (destination register index).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_kind` in 2: 00 R-type arith, 01 I-type arith, 10 branch, 11 reserved.
- `req_funct3` in 3: RISC-V funct3.
- `req_funct7b5` in 1: instruction bit 30; selects SUB for R-type funct3=000.
- `req_rs1` in 32: first operand.
- `req_rs2` in 32: second register operand.
- `req_imm` in 32: sign-extended immediate, used when `req_kind`=01.
- `req_tag` in TAG_W: returned unchanged on the response.
- `alu_op` out 3: ALUop code: 010 add, 110 sub, 000 and, 001 or.
- `alu_a` out 32: ALU `Ain`.
- `alu_b` out 32: ALU `Bin`.
- `alu_out` in 32: ALU result.
- `alu_status` in 3: {N, V, Z}. V is the signed overflow of `alu_a − alu_b`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 32: arithmetic result; 0 for branches and errors.
- `rsp_taken` out 1: branch taken; 0 for non-branches.
- `rsp_err` out 1: unsupported operation.
- `rsp_tag` out TAG_W: echo of `req_tag`.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on `req_valid & req_ready` for a supported operation.
  - IDLE → RESP for an unsupported operation.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on `rsp_ready`.
- `req_ready` = (state==IDLE) & !reset.
- Acceptance registers `alu_op`, `alu_a`, `alu_b` and the tag. `alu_b` = `req_imm` for kind 01, otherwise `req_rs2`.
- Decode, arith kinds 00/01:
  - funct3 000: add, or sub when kind=00 & funct7b5.
  - funct3 111: and.
  - funct3 110: or.
  - funct3 010 (SLT): sub; result = {31'b0, N^V}.
  - All other funct3 values: err.
- Decode, branch kind 10: always sub. Taken conditions:
  - BEQ 000: Z.
  - BNE 001: !Z.
  - BLT 100: N^V.
  - BGE 101: !(N^V).
  - BLTU/BGEU and other funct3 values: err.
- Kind 11: err.
- At the end of EXEC, `rsp_result`, `rsp_taken`, `rsp_err`=0 and `rsp_tag` are registered from `alu_out`/`alu_status`.
- Error path: `rsp_err`=1, `rsp_result`=0, `rsp_taken`=0. The ALU inputs are not updated.
- Response fields are held stable while `rsp_valid & !rsp_ready`.
- ALU inputs hold their last values outside EXEC; no toggling while idle.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready` 0 during the reset cycle, 1 the cycle after.
  - `rsp_valid` 0, `rsp_result` 0, `rsp_taken` 0, `rsp_err` 0, `rsp_tag` 0.
  - `alu_op` 000, `alu_a` 0, `alu_b` 0.
- Supported op: accept at edge 0, EXEC during cycle 1, `rsp_valid`=1 from edge 2. Latency 2 cycles.
- Unsupported op: `rsp_valid` from edge 1. Latency 1 cycle.
- Throughput: one request per 3 cycles when `rsp_ready` is held high; no overlap. `req_ready` returns in the cycle after the response handshake.
- `reset` in EXEC or RESP: aborts the operation and drops the response; state returns to IDLE.
- Arithmetic wraps modulo 2^32. Overflow is reported only through SLT/branch evaluation, never as an error.

## Test plan
- ADD: R-type funct3 000, 0x7FFFFFFF + 1, tag 3. Expect `alu_op`=010 in EXEC, `rsp_result`=0x80000000, tag 3, valid at cycle 2.
- SUB and SLT:
  - SUB (funct7b5=1): 5 − 7 gives result 0xFFFFFFFE.
  - SLT 0x80000000 vs 1 gives result 1, exercising the V/N combination.
  - SLT 1 vs 0x80000000 gives result 0.
- Branches:
  - BEQ 0x1234/0x1234 is taken.
  - BNE on the same pair is not taken.
  - BLT −1 vs 0 is taken.
  - BGE 0x7FFFFFFF vs 0x80000000 is taken; `rsp_result`=0 in all cases.
- Unsupported: BLTU, and kind 11. Expect `rsp_err`=1 with `rsp_valid` at cycle 1 and ALU inputs unchanged.
- Backpressure: hold `rsp_ready`=0 for 4 cycles. Response fields stay stable, `req_ready`=0 throughout, next request accepted one cycle after the handshake.
- Reset: assert `reset` during EXEC. Next cycle `rsp_valid`=0, outputs at reset values, and a fresh request completes normally.
